// File: rtl/frog_game_ctrl.sv
// frog_game_ctrl: game-level sequencer for the frog datapath.
//   Synchronises the four active-low direction buttons, gates the frog's
//   animate/dead controls and runs the life/respawn/game-over state machine.
//   All state advances only on cycles with i_ani_stb high.
// Ports:
//   i_clk, i_rst_n         clock, async active-low reset
//   i_ani_stb              one-cycle frame strobe
//   i_*_btn                raw buttons (low = pressed)
//   i_collide              frog overlaps a hazard (sampled on strobe)
//   i_frog_y1              frog top edge
//   o_*_btn                synchronised buttons, released outside PLAY
//   o_animate, o_dead      frog controls
//   o_lives, o_score       remaining lives, homes reached (saturating)
//   o_timer                frames remaining in the current life
//   o_state                IDLE=0 PLAY=1 DYING=2 HOME=3 RESPAWN=4 GAMEOVER=5
module frog_game_ctrl #(
  parameter int LIVES          = 3,
  parameter int RESPAWN_FRAMES = 30,
  parameter int TIME_FRAMES    = 1800,
  parameter int GOAL_Y         = 24
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ani_stb,
  input  logic        i_up_btn,
  input  logic        i_down_btn,
  input  logic        i_left_btn,
  input  logic        i_right_btn,
  input  logic        i_collide,
  input  logic [11:0] i_frog_y1,
  output logic        o_up_btn,
  output logic        o_down_btn,
  output logic        o_left_btn,
  output logic        o_right_btn,
  output logic        o_animate,
  output logic        o_dead,
  output logic [1:0]  o_lives,
  output logic [7:0]  o_score,
  output logic [10:0] o_timer,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAY     = 3'd1,
    S_DYING    = 3'd2,
    S_HOME     = 3'd3,
    S_RESPAWN  = 3'd4,
    S_GAMEOVER = 3'd5
  } state_e;

  localparam logic [1:0]  LIVES_L   = 2'(LIVES);
  localparam logic [5:0]  RESPAWN_L = 6'(RESPAWN_FRAMES);
  localparam logic [10:0] TIME_L    = 11'(TIME_FRAMES);
  localparam logic [11:0] GOAL_L    = 12'(GOAL_Y);

  // ---------------------------------------------------------------------
  // Button synchroniser, order {up, down, left, right}; idle level is 1.
  // ---------------------------------------------------------------------
  logic [3:0] btn_meta_q, btn_sync_q;
  logic       any_btn;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_meta_q <= 4'hF;
      btn_sync_q <= 4'hF;
    end else begin
      btn_meta_q <= {i_up_btn, i_down_btn, i_left_btn, i_right_btn};
      btn_sync_q <= btn_meta_q;
    end
  end

  assign any_btn = ~&btn_sync_q;

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  score_q, score_d;
  logic [10:0] timer_q, timer_d;
  logic [5:0]  resp_q,  resp_d;
  // Start is accepted in IDLE only once all buttons were seen released,
  // so the press that leaves GAMEOVER cannot also start a new game.
  logic        armed_q, armed_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      lives_q <= LIVES_L;
      score_q <= 8'd0;
      timer_q <= TIME_L;
      resp_q  <= 6'd0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      score_q <= score_d;
      timer_q <= timer_d;
      resp_q  <= resp_d;
      armed_q <= armed_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    timer_d = timer_q;
    resp_d  = resp_q;
    armed_d = armed_q;
    if (i_ani_stb) begin
      unique case (state_q)
        S_IDLE: begin
          if (!any_btn) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = S_PLAY;
            lives_d = LIVES_L;
            score_d = 8'd0;
            timer_d = TIME_L;
          end
        end
        S_PLAY: begin
          timer_d = timer_q - 11'd1;
          // Death beats reaching home on the same strobe.
          if (i_collide || timer_q == 11'd1) begin
            state_d = S_DYING;
            lives_d = lives_q - 2'd1;
          end else if (i_frog_y1 <= GOAL_L) begin
            state_d = S_HOME;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
          end
        end
        S_DYING, S_HOME: begin
          state_d = S_RESPAWN;
          resp_d  = RESPAWN_L;
        end
        S_RESPAWN: begin
          resp_d = resp_q - 6'd1;
          if (resp_q == 6'd1) begin
            if (lives_q == 2'd0) begin
              state_d = S_GAMEOVER;
            end else begin
              state_d = S_PLAY;
              timer_d = TIME_L;
            end
          end
        end
        S_GAMEOVER: begin
          if (any_btn) begin
            state_d = S_IDLE;
            armed_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // ---------------------------------------------------------------------
  always_comb begin
    o_animate = 1'b0;
    o_dead    = 1'b0;
    o_up_btn    = 1'b1;
    o_down_btn  = 1'b1;
    o_left_btn  = 1'b1;
    o_right_btn = 1'b1;
    unique case (state_q)
      S_PLAY: begin
        o_animate = 1'b1;
        {o_up_btn, o_down_btn, o_left_btn, o_right_btn} = btn_sync_q;
      end
      // One strobe with animate&&dead sends the frog back to its start.
      S_DYING, S_HOME: begin
        o_animate = 1'b1;
        o_dead    = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_lives = lives_q;
  assign o_score = score_q;
  assign o_timer = timer_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Directed bench for frog_game_ctrl: expectations are queued when a step is
// driven and popped and compared once the strobe has taken effect.
module tb_frog_game_ctrl;

  localparam int RF = 30;
  localparam int TF = 1800;

  localparam logic [2:0] IDLE = 3'd0, PLAY = 3'd1, DYING = 3'd2, HOME = 3'd3,
                         RESP = 3'd4, GOVR = 3'd5;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_ani_stb;
  logic        i_up_btn, i_down_btn, i_left_btn, i_right_btn;
  logic        i_collide;
  logic [11:0] i_frog_y1;
  logic        o_up_btn, o_down_btn, o_left_btn, o_right_btn;
  logic        o_animate, o_dead;
  logic [1:0]  o_lives;
  logic [7:0]  o_score;
  logic [10:0] o_timer;
  logic [2:0]  o_state;

  frog_game_ctrl #(
    .LIVES(3), .RESPAWN_FRAMES(RF), .TIME_FRAMES(TF), .GOAL_Y(24)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ani_stb(i_ani_stb),
    .i_up_btn(i_up_btn), .i_down_btn(i_down_btn),
    .i_left_btn(i_left_btn), .i_right_btn(i_right_btn),
    .i_collide(i_collide), .i_frog_y1(i_frog_y1),
    .o_up_btn(o_up_btn), .o_down_btn(o_down_btn),
    .o_left_btn(o_left_btn), .o_right_btn(o_right_btn),
    .o_animate(o_animate), .o_dead(o_dead), .o_lives(o_lives),
    .o_score(o_score), .o_timer(o_timer), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [1:0]  lv;
    logic [7:0]  sc;
    logic [10:0] tm;
    logic        an;
    logic        dd;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic cmp(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input string tag, input logic [2:0] st, input logic [1:0] lv,
                      input logic [7:0] sc, input logic [10:0] tm,
                      input logic an, input logic dd);
    exp_t e;
    e.tag = tag; e.st = st; e.lv = lv; e.sc = sc; e.tm = tm; e.an = an; e.dd = dd;
    q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (q.size() == 0) begin
      cmp("scoreboard_empty", 16'd1, 16'd0);
    end else begin
      e = q.pop_front();
      cmp({e.tag, ".state"},   16'(o_state),   16'(e.st));
      cmp({e.tag, ".lives"},   16'(o_lives),   16'(e.lv));
      cmp({e.tag, ".score"},   16'(o_score),   16'(e.sc));
      cmp({e.tag, ".timer"},   16'(o_timer),   16'(e.tm));
      cmp({e.tag, ".animate"}, 16'(o_animate), 16'(e.an));
      cmp({e.tag, ".dead"},    16'(o_dead),    16'(e.dd));
    end
  endtask

  // One-cycle strobe; returns on the falling edge after it took effect.
  task automatic strobe();
    @(negedge i_clk); i_ani_stb = 1'b1;
    @(negedge i_clk); i_ani_stb = 1'b0;
  endtask

  // Enough clocks for a button change to clear the synchroniser.
  task automatic settle();
    repeat (3) @(negedge i_clk);
  endtask

  task automatic step(input string tag, input logic [2:0] st, input logic [1:0] lv,
                      input logic [7:0] sc, input logic [10:0] tm,
                      input logic an, input logic dd);
    push(tag, st, lv, sc, tm, an, dd);
    strobe();
    check_out();
  endtask

  // Runs the RESPAWN strobes after the state was entered with counter RF.
  task automatic respawn(input logic [1:0] lv, input logic [7:0] sc,
                         input logic [10:0] tm_hold, input logic [2:0] nxt,
                         input logic [10:0] nxt_tm);
    for (int i = 1; i < RF; i++) step("respawn", RESP, lv, sc, tm_hold, 1'b0, 1'b0);
    step("respawn_exit", nxt, lv, sc, nxt_tm, (nxt == PLAY), 1'b0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_ani_stb = 1'b0; i_collide = 1'b0; i_frog_y1 = 12'd400;
    i_up_btn = 1'b1; i_down_btn = 1'b1; i_left_btn = 1'b1; i_right_btn = 1'b1;

    // Reset state
    #12;
    push("reset", IDLE, 2'd3, 8'd0, 11'(TF), 1'b0, 1'b0);
    check_out();
    cmp("reset.btns", 16'({o_up_btn, o_down_btn, o_left_btn, o_right_btn}), 16'hF);
    @(negedge i_clk); i_rst_n = 1'b1;

    // Start, buttons pass through in PLAY
    i_up_btn = 1'b0; settle();
    step("start", PLAY, 2'd3, 8'd0, 11'(TF), 1'b1, 1'b0);
    cmp("play.up_btn", 16'(o_up_btn), 16'd0);
    i_up_btn = 1'b1;
    step("play_tick", PLAY, 2'd3, 8'd0, 11'(TF - 1), 1'b1, 1'b0);

    // Collision
    i_collide = 1'b1;
    step("collide", DYING, 2'd2, 8'd0, 11'(TF - 2), 1'b1, 1'b1);
    i_collide = 1'b0;
    i_down_btn = 1'b0; settle();
    cmp("dying.down_btn_masked", 16'(o_down_btn), 16'd1);
    i_down_btn = 1'b1;
    step("respawn_enter", RESP, 2'd2, 8'd0, 11'(TF - 2), 1'b0, 1'b0);
    respawn(2'd2, 8'd0, 11'(TF - 2), PLAY, 11'(TF));

    // Goal
    i_frog_y1 = 12'd20;
    step("home", HOME, 2'd2, 8'd1, 11'(TF - 1), 1'b1, 1'b1);
    i_frog_y1 = 12'd400;
    step("home_respawn", RESP, 2'd2, 8'd1, 11'(TF - 1), 1'b0, 1'b0);
    respawn(2'd2, 8'd1, 11'(TF - 1), PLAY, 11'(TF));

    // Collision outranks goal
    i_frog_y1 = 12'd20; i_collide = 1'b1;
    step("goal_vs_collide", DYING, 2'd1, 8'd1, 11'(TF - 1), 1'b1, 1'b1);
    i_frog_y1 = 12'd400; i_collide = 1'b0;
    step("gvc_respawn", RESP, 2'd1, 8'd1, 11'(TF - 1), 1'b0, 1'b0);
    respawn(2'd1, 8'd1, 11'(TF - 1), PLAY, 11'(TF));

    // Timeout on the last life leads to GAMEOVER
    for (int k = 1; k < TF; k++)
      step("timeout_tick", PLAY, 2'd1, 8'd1, 11'(TF - k), 1'b1, 1'b0);
    step("timeout", DYING, 2'd0, 8'd1, 11'd0, 1'b1, 1'b1);
    step("to_respawn", RESP, 2'd0, 8'd1, 11'd0, 1'b0, 1'b0);
    respawn(2'd0, 8'd1, 11'd0, GOVR, 11'd0);
    step("gameover_hold", GOVR, 2'd0, 8'd1, 11'd0, 1'b0, 1'b0);

    // Game-over exit needs a release before a new start
    i_left_btn = 1'b0; settle();
    step("go_exit", IDLE, 2'd0, 8'd1, 11'd0, 1'b0, 1'b0);
    step("idle_unarmed", IDLE, 2'd0, 8'd1, 11'd0, 1'b0, 1'b0);
    i_left_btn = 1'b1; settle();
    step("idle_arm", IDLE, 2'd0, 8'd1, 11'd0, 1'b0, 1'b0);
    i_left_btn = 1'b0; settle();
    step("restart", PLAY, 2'd3, 8'd0, 11'(TF), 1'b1, 1'b0);
    i_left_btn = 1'b1;

    // Asynchronous reset while DYING
    i_collide = 1'b1;
    step("collide2", DYING, 2'd2, 8'd0, 11'(TF - 1), 1'b1, 1'b1);
    i_collide = 1'b0;
    @(negedge i_clk); #1 i_rst_n = 1'b0; #1;
    push("async_reset", IDLE, 2'd3, 8'd0, 11'(TF), 1'b0, 1'b0);
    check_out();
    @(negedge i_clk); i_rst_n = 1'b1;

    // Score saturation over 256 homes
    i_up_btn = 1'b0; settle();
    step("start3", PLAY, 2'd3, 8'd0, 11'(TF), 1'b1, 1'b0);
    i_up_btn = 1'b1;
    for (int h = 1; h <= 256; h++) begin
      i_frog_y1 = 12'd20;
      step("sat_home", HOME, 2'd3, (h > 255) ? 8'd255 : 8'(h), 11'(TF - 1), 1'b1, 1'b1);
      i_frog_y1 = 12'd400;
      repeat (RF) strobe();
      step("sat_back", PLAY, 2'd3, (h > 255) ? 8'd255 : 8'(h), 11'(TF), 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
